// File: rtl/midi_tx_pkg.sv
// rtl/midi_tx_pkg.sv - shared types and constants for the MIDI OUT encoder
// Purpose: event type encoding, channel-message status nibbles, encoder
//          state encoding and small helpers used by the encoder top level.
// Ports:   none (package)
package midi_tx_pkg;

  typedef enum logic [2:0] {
    EV_NOTE_OFF = 3'd0,
    EV_NOTE_ON  = 3'd1,
    EV_CTRL     = 3'd2,
    EV_PRG_CH   = 3'd3,
    EV_PITCH    = 3'd4
  } ev_type_t;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_CTRL     = 4'hB;
  localparam logic [3:0] ST_PRG_CH   = 4'hC;
  localparam logic [3:0] ST_PITCH    = 4'hE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ST   = 2'd1,
    D1   = 2'd2,
    D2   = 2'd3
  } enc_state_t;

  // Codes 5-7 carry no MIDI message.
  function automatic logic type_is_valid(input logic [2:0] t);
    return (t <= 3'd4);
  endfunction

  function automatic logic [3:0] status_nibble(input logic [2:0] t);
    logic [3:0] n;
    case (t)
      EV_NOTE_OFF: n = ST_NOTE_OFF;
      EV_NOTE_ON:  n = ST_NOTE_ON;
      EV_CTRL:     n = ST_CTRL;
      EV_PRG_CH:   n = ST_PRG_CH;
      EV_PITCH:    n = ST_PITCH;
      default:     n = 4'h0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/midi_out_encoder_if.sv
// rtl/midi_out_encoder_if.sv - channel-event handshake bundle for the MIDI OUT encoder
// Purpose: groups the event valid/ready handshake and its payload.
// Signals: ev_valid, ev_ready, ev_type[2:0], ev_ch[3:0], ev_d1[6:0], ev_d2[6:0]
// Modports: master (event producer), slave (encoder)
interface midi_out_encoder_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [2:0] ev_type;
  logic [3:0] ev_ch;
  logic [6:0] ev_d1;
  logic [6:0] ev_d2;

  modport master (
    output ev_valid, ev_type, ev_ch, ev_d1, ev_d2,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_type, ev_ch, ev_d1, ev_d2,
    output ev_ready
  );
endinterface

// File: rtl/midi_uart_tx.sv
// rtl/midi_uart_tx.sv - 8N1 serializer for the MIDI OUT line
// Purpose: shifts one byte out as start(0), 8 data bits LSB first, stop(1),
//          each bit DIV clocks long; txd is a registered output.
// Ports:   data_clk, reset_reg_N (async, active-low), tx_load, tx_byte[7:0],
//          tx_idle (load may be taken this cycle), txd (serial out, idles high)
module midi_uart_tx #(
  parameter int DIV = 1600
) (
  input  logic       data_clk,
  input  logic       reset_reg_N,
  input  logic       tx_load,
  input  logic [7:0] tx_byte,
  output logic       tx_idle,
  output logic       txd
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic          active_q;
  logic [3:0]    idx_q;
  logic [CW-1:0] cnt_q;
  logic [9:0]    frame_q;
  logic          txd_q;
  logic          last_tick;
  logic          frame_end;

  assign last_tick = (cnt_q == CW'(DIV - 1));
  assign frame_end = active_q && (idx_q == 4'd9) && last_tick;

  // Idle is also reported during the final clock of the stop bit: a load taken
  // then starts the next frame with no gap, because txd trails the bit state
  // by one register stage.
  assign tx_idle = !active_q || frame_end;
  assign txd     = txd_q;

  always_ff @(posedge data_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      active_q <= 1'b0;
      idx_q    <= 4'd0;
      cnt_q    <= '0;
      frame_q  <= '1;
      txd_q    <= 1'b1;
    end else begin
      txd_q <= active_q ? frame_q[idx_q] : 1'b1;
      if (tx_load && tx_idle) begin
        active_q <= 1'b1;
        idx_q    <= 4'd0;
        cnt_q    <= '0;
        frame_q  <= {1'b1, tx_byte, 1'b0};
      end else if (active_q) begin
        if (last_tick) begin
          cnt_q <= '0;
          if (idx_q == 4'd9) begin
            active_q <= 1'b0;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/midi_out_encoder.sv
// rtl/midi_out_encoder.sv - MIDI channel-message encoder with running status
// Purpose: accepts one channel event per handshake, sequences status/data
//          bytes (skipping a repeated status under running status) into the
//          8N1 serializer.
// Ports:   data_clk, reset_reg_N (async, active-low), ev (event handshake,
//          slave side), running_status_en, midi_txd (serial out), busy
module midi_out_encoder
  import midi_tx_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 31250
) (
  input  logic                 data_clk,
  input  logic                 reset_reg_N,
  midi_out_encoder_if.slave    ev,
  input  logic                 running_status_en,
  output logic                 midi_txd,
  output logic                 busy
);

  localparam int DIV = CLK_HZ / BAUD;

  enc_state_t state_q, state_d;
  logic [7:0] status_q, status_d;
  logic [6:0] d1_q, d1_d;
  logic [6:0] d2_q, d2_d;
  logic       prg_q, prg_d;
  logic [7:0] last_st_q, last_st_d;
  logic       last_v_q, last_v_d;
  logic       init_q;
  logic [1:0] idle_h_q;

  logic       tx_load;
  logic [7:0] tx_byte;
  logic       tx_idle;
  logic       load_status;
  logic [7:0] status_w;
  logic       accept;
  logic       skip_status;
  logic       quiet;

  midi_uart_tx #(.DIV(DIV)) u_tx (
    .data_clk   (data_clk),
    .reset_reg_N(reset_reg_N),
    .tx_load    (tx_load),
    .tx_byte    (tx_byte),
    .tx_idle    (tx_idle),
    .txd        (midi_txd)
  );

  // tx_idle rises one clock before the stop bit's last clock so bytes chain
  // gap-free; new events wait two more clocks until the stop bit has fully
  // left the txd register.
  assign quiet       = (state_q == IDLE) && tx_idle && (&idle_h_q);
  assign ev.ev_ready = init_q && quiet;
  assign busy        = !quiet;

  assign status_w    = {status_nibble(ev.ev_type), ev.ev_ch};
  assign accept      = ev.ev_valid && ev.ev_ready;
  assign skip_status = running_status_en && last_v_q && (status_w == last_st_q);

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    prg_d       = prg_q;
    tx_load     = 1'b0;
    tx_byte     = 8'h00;
    load_status = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && type_is_valid(ev.ev_type)) begin
          status_d = status_w;
          d1_d     = ev.ev_d1;
          d2_d     = ev.ev_d2;
          prg_d    = (ev.ev_type == EV_PRG_CH);
          state_d  = skip_status ? D1 : ST;
        end
      end
      ST: begin
        if (tx_idle) begin
          tx_load     = 1'b1;
          tx_byte     = status_q;
          load_status = 1'b1;
          state_d     = D1;
        end
      end
      D1: begin
        if (tx_idle) begin
          tx_load = 1'b1;
          tx_byte = {1'b0, d1_q};
          state_d = prg_q ? IDLE : D2;
        end
      end
      D2: begin
        if (tx_idle) begin
          tx_load = 1'b1;
          tx_byte = {1'b0, d2_q};
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Disabling running status forgets the remembered status immediately.
  assign last_v_d  = running_status_en ? (last_v_q | load_status) : 1'b0;
  assign last_st_d = load_status ? status_q : last_st_q;

  always_ff @(posedge data_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q   <= IDLE;
      status_q  <= 8'h00;
      d1_q      <= 7'h00;
      d2_q      <= 7'h00;
      prg_q     <= 1'b0;
      last_st_q <= 8'h00;
      last_v_q  <= 1'b0;
      init_q    <= 1'b0;
      idle_h_q  <= 2'b11;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      prg_q     <= prg_d;
      last_st_q <= last_st_d;
      last_v_q  <= last_v_d;
      init_q    <= 1'b1;
      idle_h_q  <= {idle_h_q[0], tx_idle};
    end
  end

endmodule

// File: tb/tb_midi_out_encoder.sv
// tb/tb_midi_out_encoder.sv - self-checking bench for midi_out_encoder
module tb_midi_out_encoder;

  localparam int DIV = 10;

  logic data_clk;
  logic reset_reg_N;
  logic running_status_en;
  logic midi_txd;
  logic busy;
  logic ev_ready;

  midi_out_encoder_if ev_if();

  midi_out_encoder #(.CLK_HZ(312500), .BAUD(31250)) dut (
    .data_clk         (data_clk),
    .reset_reg_N      (reset_reg_N),
    .ev               (ev_if),
    .running_status_en(running_status_en),
    .midi_txd         (midi_txd),
    .busy             (busy)
  );

  assign ev_ready = ev_if.ev_ready;

  initial data_clk = 1'b0;
  always #5 data_clk = ~data_clk;

  int cyc = 0;
  always @(posedge data_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];
  logic [7:0] tb_last = 8'h00;
  logic       tb_lv   = 1'b0;
  logic       mon_busy = 1'b0;

  function automatic logic [3:0] nib(input logic [2:0] t);
    case (t)
      3'd0: return 4'h8;
      3'd1: return 4'h9;
      3'd2: return 4'hB;
      3'd3: return 4'hC;
      default: return 4'hE;
    endcase
  endfunction

  function automatic int span();
    if (start_q.size() == 0) return 0;
    return start_q[start_q.size()-1] - start_q[0] + 10*DIV;
  endfunction

  // Line monitor: decodes each 8N1 frame mid-bit and checks it against the scoreboard.
  initial begin
    int         cnt;
    logic [7:0] sh;
    logic       sb;
    logic [7:0] e;
    cnt = 0; sh = 8'h00; sb = 1'b0;
    forever begin
      @(negedge data_clk);
      if (!reset_reg_N) begin
        mon_busy = 1'b0;
      end else if (!mon_busy) begin
        if (midi_txd === 1'b0) begin
          mon_busy = 1'b1;
          cnt = 0;
          start_q.push_back(cyc);
        end
      end else begin
        cnt++;
        if (cnt % DIV == DIV/2) begin
          if (cnt / DIV == 0) sb = midi_txd;
          else if (cnt / DIV <= 8) sh[cnt/DIV - 1] = midi_txd;
          else begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL serial_byte: got %02h with no byte expected", sh);
            end else begin
              e = exp_q.pop_front();
              if (sh !== e || sb !== 1'b0 || midi_txd !== 1'b1) begin
                errors++;
                $display("FAIL serial_byte: got %02h start=%b stop=%b, expected %02h start=0 stop=1",
                         sh, sb, midi_txd, e);
              end
            end
            mon_busy = 1'b0;
          end
        end
      end
    end
  end

  task automatic send_event(input logic [2:0] t, input logic [3:0] ch, input logic [6:0] d1,
                            input logic [6:0] d2, input logic rs);
    int n;
    logic [7:0] st;
    @(posedge data_clk); #1;
    ev_if.ev_type = t; ev_if.ev_ch = ch; ev_if.ev_d1 = d1; ev_if.ev_d2 = d2;
    running_status_en = rs;
    ev_if.ev_valid = 1'b1;
    n = 0;
    while (!ev_ready && n < 3000) begin
      @(posedge data_clk); #1;
      n++;
    end
    if (!ev_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: ev_ready=%b, expected 1 within 3000 cycles", ev_ready);
      ev_if.ev_valid = 1'b0;
      return;
    end
    if (t <= 3'd4) begin
      st = {nib(t), ch};
      if (!(rs && tb_lv && st == tb_last)) begin
        exp_q.push_back(st);
        tb_last = st;
      end
      tb_lv = rs;
      exp_q.push_back({1'b0, d1});
      if (t != 3'd3) exp_q.push_back({1'b0, d2});
    end else if (!rs) begin
      tb_lv = 1'b0;
    end
    @(posedge data_clk); #1;
    ev_if.ev_valid = 1'b0;
    ev_if.ev_type = 3'($urandom); ev_if.ev_ch = 4'($urandom);
    ev_if.ev_d1 = 7'($urandom); ev_if.ev_d2 = 7'($urandom);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge data_clk);
    while (!(ev_ready && !mon_busy && exp_q.size() == 0) && n < 4000) begin
      @(negedge data_clk);
      n++;
    end
    checks++;
    if (n >= 4000) begin
      errors++;
      $display("FAIL %s_idle: ready=%b pending=%0d, expected idle within 4000 cycles",
               tag, ev_ready, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset_reg_N = 1'b0;
    repeat (3) @(posedge data_clk);
    #1;
    checks++;
    if (midi_txd !== 1'b1 || ev_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: txd=%b ready=%b busy=%b, expected 1 0 0", midi_txd, ev_ready, busy);
    end
    reset_reg_N = 1'b1;
    @(posedge data_clk); #1;
    checks++;
    if (ev_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b busy=%b, expected 1 0", ev_ready, busy);
    end
  endtask

  task automatic test_basic();
    start_q.delete();
    send_event(3'd1, 4'd0, 7'h3C, 7'h64, 1'b0);
    checks++;
    if (midi_txd !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_accept: txd=%b busy=%b, expected 1 1", midi_txd, busy);
    end
    @(posedge data_clk); #1;
    checks++;
    if (midi_txd !== 1'b1) begin
      errors++;
      $display("FAIL basic_n1: txd=%b, expected 1", midi_txd);
    end
    @(posedge data_clk); #1;
    checks++;
    if (midi_txd !== 1'b0) begin
      errors++;
      $display("FAIL basic_n2: txd=%b, expected 0", midi_txd);
    end
    wait_idle("basic");
    checks++;
    if (start_q.size() != 3 || span() != 30*DIV) begin
      errors++;
      $display("FAIL basic_span: bytes=%0d clocks=%0d, expected 3 %0d", start_q.size(), span(), 30*DIV);
    end
  endtask

  task automatic test_running_status();
    send_event(3'd1, 4'd3, 7'h40, 7'h7F, 1'b1);
    wait_idle("rs1");
    start_q.delete();
    send_event(3'd1, 4'd3, 7'h40, 7'h00, 1'b1);
    wait_idle("rs2");
    checks++;
    if (start_q.size() != 2 || span() != 20*DIV) begin
      errors++;
      $display("FAIL rs_span: bytes=%0d clocks=%0d, expected 2 %0d", start_q.size(), span(), 20*DIV);
    end
  endtask

  task automatic test_status_change();
    start_q.delete();
    send_event(3'd3, 4'd5, 7'h0A, 7'h55, 1'b1);
    wait_idle("prg1");
    checks++;
    if (span() != 20*DIV) begin
      errors++;
      $display("FAIL prg_span: clocks=%0d, expected %0d", span(), 20*DIV);
    end
    start_q.delete();
    send_event(3'd3, 4'd5, 7'h0B, 7'h2A, 1'b1);
    wait_idle("prg2");
    checks++;
    if (span() != 10*DIV) begin
      errors++;
      $display("FAIL prg_rs_span: clocks=%0d, expected %0d", span(), 10*DIV);
    end
    start_q.delete();
    send_event(3'd4, 4'd5, 7'h00, 7'h40, 1'b1);
    wait_idle("pitch");
    checks++;
    if (span() != 30*DIV) begin
      errors++;
      $display("FAIL pitch_span: clocks=%0d, expected %0d", span(), 30*DIV);
    end
  endtask

  task automatic test_invalid();
    start_q.delete();
    send_event(3'd6, 4'd2, 7'h12, 7'h34, 1'b1);
    checks++;
    if (ev_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL invalid_ready: ready=%b busy=%b, expected 1 0", ev_ready, busy);
    end
    repeat (3*DIV) @(posedge data_clk);
    #1;
    checks++;
    if (start_q.size() != 0) begin
      errors++;
      $display("FAIL invalid_quiet: frames=%0d, expected 0", start_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    int acc_cyc[2];
    int n;
    wait_idle("hold_pre");
    @(posedge data_clk); #1;
    ev_if.ev_type = 3'd1; ev_if.ev_ch = 4'd2; ev_if.ev_d1 = 7'h11; ev_if.ev_d2 = 7'h22;
    running_status_en = 1'b0;
    tb_lv = 1'b0;
    ev_if.ev_valid = 1'b1;
    acc = 0; n = 0;
    while (acc < 2 && n < 80*DIV) begin
      @(negedge data_clk);
      n++;
      if (ev_ready) begin
        exp_q.push_back(8'h92); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        acc_cyc[acc] = cyc;
        acc++;
      end
    end
    @(posedge data_clk); #1;
    ev_if.ev_valid = 1'b0;
    checks++;
    if (acc != 2 || acc_cyc[1] - acc_cyc[0] != 30*DIV + 3) begin
      errors++;
      $display("FAIL hold_accepts: accepts=%0d spacing=%0d, expected 2 %0d",
               acc, (acc == 2) ? acc_cyc[1] - acc_cyc[0] : -1, 30*DIV + 3);
    end
    wait_idle("hold");
  endtask

  task automatic test_rs_disabled();
    start_q.delete();
    send_event(3'd1, 4'd1, 7'h30, 7'h50, 1'b0);
    send_event(3'd1, 4'd1, 7'h30, 7'h50, 1'b0);
    wait_idle("rsoff");
    checks++;
    if (start_q.size() != 6) begin
      errors++;
      $display("FAIL rsoff_bytes: bytes=%0d, expected 6", start_q.size());
    end
  endtask

  task automatic test_reset_mid();
    send_event(3'd1, 4'd0, 7'h3C, 7'h64, 1'b0);
    repeat (1 + 4*DIV + DIV/2) @(posedge data_clk);
    #1;
    reset_reg_N = 1'b0;
    #1;
    checks++;
    if (midi_txd !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_line: txd=%b busy=%b, expected 1 0", midi_txd, busy);
    end
    exp_q.delete();
    tb_lv = 1'b0;
    repeat (3) @(posedge data_clk);
    #1;
    reset_reg_N = 1'b1;
    @(posedge data_clk); #1;
    checks++;
    if (ev_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: ready=%b, expected 1", ev_ready);
    end
    start_q.delete();
    send_event(3'd1, 4'd0, 7'h3C, 7'h64, 1'b1);
    wait_idle("midreset");
    checks++;
    if (start_q.size() != 3) begin
      errors++;
      $display("FAIL midreset_bytes: bytes=%0d, expected 3", start_q.size());
    end
  endtask

  initial begin
    ev_if.ev_valid = 1'b0; ev_if.ev_type = 3'd0; ev_if.ev_ch = 4'd0;
    ev_if.ev_d1 = 7'd0; ev_if.ev_d2 = 7'd0;
    running_status_en = 1'b0;
    reset_reg_N = 1'b0;
    test_reset();
    test_basic();
    test_running_status();
    test_status_change();
    test_invalid();
    test_back_to_back();
    test_rs_disabled();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
